// File: rtl/spring_controller_if.sv
// rtl/spring_controller_if.sv - spring controller frame/key/collision bus with master (driver) and slave (controller) views
interface spring_controller_if;
    logic               startOfFrame;
    logic               keyIsPressed;
    logic               pause;
    logic               reset_level;
    logic               collisionSmileySpring;
    logic signed [31:0] springSpeedY;
    logic [7:0]         springCompression;
    logic               collisionSmileySpringPulse;

    modport master (
        output startOfFrame, keyIsPressed, pause, reset_level, collisionSmileySpring,
        input  springSpeedY, springCompression, collisionSmileySpringPulse
    );

    modport slave (
        input  startOfFrame, keyIsPressed, pause, reset_level, collisionSmileySpring,
        output springSpeedY, springCompression, collisionSmileySpringPulse
    );
endinterface

// File: rtl/spring_controller.sv
// rtl/spring_controller.sv - launch spring FSM (charge/release/cooldown) plus collision edge pulse
// Optional auto-fire after holding full charge: define SPRING_AUTO_FIRE_EN.
module spring_controller #(
    parameter int MAX_COMPRESSION  = 40,
    parameter int CHARGE_STEP      = 1,
    parameter int RELEASE_STEP     = 8,
    parameter int SPEED_PER_PIXEL  = 16,
    parameter int COOLDOWN_FRAMES  = 30,
    parameter int AUTO_FIRE_FRAMES = 60
) (
    input logic               clk,
    input logic               resetN,
    spring_controller_if.slave bus
);

    localparam logic [7:0] MAX_C     = 8'(MAX_COMPRESSION);
    localparam logic [7:0] CHARGE_C  = 8'(CHARGE_STEP);
    localparam logic [7:0] RELEASE_C = 8'(RELEASE_STEP);
    localparam int         CD_W      = $clog2(COOLDOWN_FRAMES + 2);

    typedef enum logic [1:0] {IDLE, CHARGING, RELEASING, COOLDOWN} springState_t;

    springState_t       state;
    logic [7:0]         compression;
    logic signed [31:0] speedY;
    logic               pulse;
    logic               collD;
    logic [CD_W-1:0]    cooldownCnt;

    logic               frameTick;
    logic [8:0]         chargeSum;
    logic [7:0]         chargeNext;
    logic [7:0]         releaseNext;
    logic signed [31:0] launchSpeed;
    logic               autoFireNow;

    assign frameTick   = bus.startOfFrame & ~bus.pause;
    assign chargeSum   = {1'b0, compression} + {1'b0, CHARGE_C};
    assign chargeNext  = (chargeSum > {1'b0, MAX_C}) ? MAX_C : chargeSum[7:0];
    assign releaseNext = (compression > RELEASE_C) ? (compression - RELEASE_C) : 8'd0;
    assign launchSpeed = -(int'(compression) * SPEED_PER_PIXEL);

`ifdef SPRING_AUTO_FIRE_EN
    localparam int AF_W = $clog2(AUTO_FIRE_FRAMES + 2);
    logic [AF_W-1:0] autoCnt;
    logic            atMax;
    assign atMax       = (compression == MAX_C);
    assign autoFireNow = atMax && (autoCnt == AF_W'(AUTO_FIRE_FRAMES - 1));
`else
    assign autoFireNow = 1'b0;
`endif

    // Free-running so that leaving reset never sees a stale level and fakes an edge.
    always_ff @(posedge clk) begin
        collD <= bus.collisionSmileySpring;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            compression <= 8'd0;
            speedY      <= 32'sd0;
            pulse       <= 1'b0;
            cooldownCnt <= '0;
`ifdef SPRING_AUTO_FIRE_EN
            autoCnt     <= '0;
`endif
        end else if (bus.reset_level) begin
            state       <= IDLE;
            compression <= 8'd0;
            speedY      <= 32'sd0;
            pulse       <= 1'b0;
            cooldownCnt <= '0;
`ifdef SPRING_AUTO_FIRE_EN
            autoCnt     <= '0;
`endif
        end else begin
            pulse <= bus.collisionSmileySpring & ~collD;
            if (frameTick) begin
                case (state)
                    IDLE: begin
                        if (bus.keyIsPressed) begin
                            state       <= CHARGING;
                            compression <= chargeNext;
                        end
                    end
                    CHARGING: begin
                        if (!bus.keyIsPressed || autoFireNow) begin
                            state  <= RELEASING;
                            speedY <= launchSpeed;
`ifdef SPRING_AUTO_FIRE_EN
                            autoCnt <= '0;
`endif
                        end else begin
                            compression <= chargeNext;
`ifdef SPRING_AUTO_FIRE_EN
                            if (atMax) autoCnt <= autoCnt + 1'b1;
`endif
                        end
                    end
                    RELEASING: begin
                        compression <= releaseNext;
                        if (releaseNext == 8'd0) begin
                            state       <= COOLDOWN;
                            speedY      <= 32'sd0;
                            cooldownCnt <= CD_W'(COOLDOWN_FRAMES);
                        end
                    end
                    COOLDOWN: begin
                        if (cooldownCnt <= CD_W'(1)) begin
                            state       <= IDLE;
                            cooldownCnt <= '0;
                        end else begin
                            cooldownCnt <= cooldownCnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.springSpeedY               = speedY;
    assign bus.springCompression          = compression;
    assign bus.collisionSmileySpringPulse = pulse;

endmodule

// File: tb/tb_spring_controller.sv
// tb/tb_spring_controller.sv - randomized and directed bench for spring_controller against a frame-level model
`timescale 1ns/1ps
module tb_spring_controller;

    localparam int MAXC  = 40;
    localparam int RSTEP = 8;
    localparam int SPP   = 16;
    localparam int COOL  = 30;
    localparam int AUTOF = 60;

    logic clk;
    logic resetN;
    spring_controller_if bus();

    spring_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level model: launch speed nonzero means the spring is flying back,
    // a positive cooldown count means it is resting.
    int mComp = 0;
    int mSpeed = 0;
    int mCool = 0;
    int mHeld = 0;
    bit mCharging = 0;
    bit mPulse = 0;
    bit mPrevColl = 0;
    bit collLvl = 0;

    task automatic checkVal(input string tag, input longint observed, input longint expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge(input bit sof, input bit key, input bit pz, input bit rl,
                             input bit coll, input bit rn);
        bit fire;
        if (!rn || rl) begin
            mComp = 0; mSpeed = 0; mCool = 0; mHeld = 0; mCharging = 0; mPulse = 0;
        end else begin
            mPulse = coll && !mPrevColl;
            if (sof && !pz) begin
                if (mCool > 0) begin
                    mCool--;
                end else if (mSpeed != 0) begin
                    mComp = (mComp > RSTEP) ? mComp - RSTEP : 0;
                    if (mComp == 0) begin
                        mSpeed = 0;
                        mCool = COOL;
                    end
                end else if (mCharging) begin
                    fire = !key;
`ifdef SPRING_AUTO_FIRE_EN
                    if (key && mComp == MAXC) begin
                        mHeld++;
                        if (mHeld == AUTOF) fire = 1;
                    end
`endif
                    if (fire) begin
                        mSpeed = -(mComp * SPP);
                        mCharging = 0;
                        mHeld = 0;
                    end else begin
                        mComp = (mComp + 1 > MAXC) ? MAXC : mComp + 1;
                    end
                end else if (key) begin
                    mCharging = 1;
                    mComp = 1;
                end
            end
        end
        mPrevColl = coll;
    endtask

    task automatic step(input bit sof, input bit key, input bit pz, input bit rl,
                        input bit coll, input bit rn);
        bus.startOfFrame          = sof;
        bus.keyIsPressed          = key;
        bus.pause                 = pz;
        bus.reset_level           = rl;
        bus.collisionSmileySpring = coll;
        resetN                    = rn;
        @(posedge clk);
        modelEdge(sof, key, pz, rl, coll, rn);
        #1;
        checkVal("compression", bus.springCompression, mComp);
        checkVal("speedY", bus.springSpeedY, mSpeed);
        checkVal("pulse", bus.collisionSmileySpringPulse, mPulse);
    endtask

    task automatic frame(input bit key);
        step(1, key, 0, 0, collLvl, 1);
        step(0, key, 0, 0, collLvl, 1);
    endtask

    task automatic levelReset();
        step(0, 0, 0, 1, collLvl, 1);
    endtask

    int pulses;
    bit rKey, rPause, rColl;

    initial begin
        bus.startOfFrame = 0; bus.keyIsPressed = 0; bus.pause = 0;
        bus.reset_level = 0; bus.collisionSmileySpring = 0; resetN = 0;
        repeat (3) step(0, 0, 0, 0, 0, 0);
        checkVal("rst_comp", bus.springCompression, 0);
        checkVal("rst_speed", bus.springSpeedY, 0);
        checkVal("rst_pulse", bus.collisionSmileySpringPulse, 0);

        // Charge 10, release, fly back, then cooldown swallows a held key.
        repeat (10) frame(1);
        checkVal("chg10_comp", bus.springCompression, 10);
        frame(0);
        checkVal("rel10_speed", bus.springSpeedY, -160);
        checkVal("rel10_comp", bus.springCompression, 10);
        frame(0);
        checkVal("rel10_comp2", bus.springCompression, 2);
        frame(0);
        checkVal("rel10_comp0", bus.springCompression, 0);
        checkVal("rel10_speed0", bus.springSpeedY, 0);
        repeat (COOL) frame(1);
        checkVal("cool_nocharge", bus.springCompression, 0);
        frame(1);
        checkVal("cool_then_charge", bus.springCompression, 1);

        // Saturation at full charge.
        levelReset();
        repeat (50) frame(1);
        checkVal("sat_comp", bus.springCompression, 40);
        frame(0);
        checkVal("sat_speed", bus.springSpeedY, -640);
        repeat (4) frame(0);
        checkVal("sat_comp8", bus.springCompression, 8);
        checkVal("sat_speed_held", bus.springSpeedY, -640);
        frame(0);
        checkVal("sat_comp0", bus.springCompression, 0);

        // Pause mid-charge ignores a key release, then reset_level mid-flight.
        levelReset();
        repeat (12) frame(1);
        repeat (20) begin
            step(1, 0, 1, 0, collLvl, 1);
            step(0, 0, 1, 0, collLvl, 1);
        end
        checkVal("pause_comp", bus.springCompression, 12);
        checkVal("pause_speed", bus.springSpeedY, 0);
        frame(1);
        checkVal("unpause_comp", bus.springCompression, 13);
        frame(0);
        checkVal("p_rel_speed", bus.springSpeedY, -208);
        frame(0);
        checkVal("p_rel_comp", bus.springCompression, 5);
        step(1, 1, 0, 1, collLvl, 1);
        checkVal("rl_comp", bus.springCompression, 0);
        checkVal("rl_speed", bus.springSpeedY, 0);

        // Auto-fire (or indefinite hold) at full charge.
        repeat (100) frame(1);
`ifdef SPRING_AUTO_FIRE_EN
        checkVal("auto_speed", bus.springSpeedY, -640);
`else
        checkVal("auto_speed", bus.springSpeedY, 0);
`endif
        checkVal("auto_comp", bus.springCompression, 40);

        // Held collision: one pulse, one clk after the rise.
        levelReset();
        collLvl = 1;
        step(0, 0, 0, 0, 1, 1);
        checkVal("pulse_rise", bus.collisionSmileySpringPulse, 1);
        pulses = 0;
        repeat (99) begin
            step(0, 0, 0, 0, 1, 1);
            pulses += int'(bus.collisionSmileySpringPulse);
        end
        checkVal("pulse_held_extra", pulses, 0);
        collLvl = 0;
        step(0, 0, 0, 0, 0, 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, (i % 2 == 0), 1);
            pulses += int'(bus.collisionSmileySpringPulse);
        end
        checkVal("pulse_toggle", pulses, 4);

        // Collision edge coincident with reset_level is suppressed.
        step(0, 0, 0, 1, 1, 1);
        checkVal("pulse_rl", bus.collisionSmileySpringPulse, 0);
        step(0, 0, 0, 0, 0, 1);

        // Random traffic.
        rKey = 0; rPause = 0; rColl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(149, 0) == 0) rKey = ~rKey;
            if ($urandom_range(59, 0) == 0) rPause = ~rPause;
            if ($urandom_range(3, 0) == 0) rColl = ~rColl;
            step($urandom_range(2, 0) == 0, rKey, rPause,
                 $urandom_range(599, 0) == 0, rColl, $urandom_range(1499, 0) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
